// File: rtl/drf_gpio_ports.sv
// Memory-mapped GPIO block: PORT_COUNT ports, each with an output latch, direction
// register, input synchronizer and sticky rising-edge flags feeding one IRQ line.
module drf_gpio_ports #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PORT_COUNT  = 4,
  parameter int unsigned PORT_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            in_addr,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_write_en,
  input  logic                             in_read_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_read_valid,
  input  logic [PORT_COUNT*PORT_WIDTH-1:0] in_port,
  output logic [PORT_COUNT*PORT_WIDTH-1:0] out_port,
  output logic [PORT_COUNT*PORT_WIDTH-1:0] out_port_oe,
  output logic                             out_irq
);

  localparam int unsigned PIN_COUNT = PORT_COUNT * PORT_WIDTH;
  localparam int unsigned REG_COUNT = PORT_COUNT * 4;
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;
  localparam int unsigned ARM_WIDTH = $clog2(SYNC_STAGES + 2);
  localparam int unsigned ARM_DONE  = SYNC_STAGES + 1;

  logic [PIN_COUNT-1:0]  sync_q [SYNC_STAGES];
  logic [PIN_COUNT-1:0]  delay_q;
  logic [PIN_COUNT-1:0]  flags_q;
  logic [PORT_COUNT-1:0] irq_en_q;
  logic [ARM_WIDTH-1:0]  arm_cnt_q;

  logic                  armed_c;
  logic                  addr_hit_c;
  logic [IDX_WIDTH-1:0]  port_sel_c;
  logic [1:0]            reg_sel_c;
  logic [PORT_COUNT-1:0] wr_out_c;
  logic [PORT_COUNT-1:0] wr_dir_c;
  logic [PORT_COUNT-1:0] wr_flg_c;
  logic [PIN_COUNT-1:0]  clr_c;
  logic [PIN_COUNT-1:0]  rise_c;
  logic [PIN_COUNT-1:0]  ie_mask_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  ie_wdata_c;
  logic                  unused_data_c;

  assign port_sel_c    = in_addr[ADDR_WIDTH-1:2];
  assign reg_sel_c     = in_addr[1:0];
  assign addr_hit_c    = 32'(in_addr) < REG_COUNT;
  assign armed_c       = arm_cnt_q == ARM_WIDTH'(ARM_DONE);
  assign rise_c        = sync_q[SYNC_STAGES-1] & ~delay_q & {PIN_COUNT{armed_c}};
  assign unused_data_c = ^in_data;

  // IRQ enable lives just above the pin bits, only when the bus has room for it
  if (PORT_WIDTH < DATA_WIDTH) begin : g_ie
    assign ie_wdata_c = in_data[PORT_WIDTH];
  end else begin : g_no_ie
    assign ie_wdata_c = 1'b0;
  end

  // Address decode: write strobes, W1C mask, IRQ mask and read mux
  always_comb begin
    wr_out_c  = '0;
    wr_dir_c  = '0;
    wr_flg_c  = '0;
    clr_c     = '0;
    ie_mask_c = '0;
    rdata_c   = '0;
    for (int p = 0; p < int'(PORT_COUNT); p++) begin
      ie_mask_c[p*PORT_WIDTH +: PORT_WIDTH] = {PORT_WIDTH{irq_en_q[p]}};
      if (addr_hit_c && (32'(port_sel_c) == 32'(p))) begin
        if (in_write_en) begin
          case (reg_sel_c)
            2'd0:    wr_out_c[p] = 1'b1;
            2'd1:    wr_dir_c[p] = 1'b1;
            2'd3:    wr_flg_c[p] = 1'b1;
            default: ;
          endcase
        end
        if (wr_flg_c[p]) clr_c[p*PORT_WIDTH +: PORT_WIDTH] = in_data[PORT_WIDTH-1:0];
        case (reg_sel_c)
          2'd0: rdata_c = DATA_WIDTH'(out_port[p*PORT_WIDTH +: PORT_WIDTH]);
          2'd1: rdata_c = DATA_WIDTH'(out_port_oe[p*PORT_WIDTH +: PORT_WIDTH]);
          2'd2: rdata_c = DATA_WIDTH'(sync_q[SYNC_STAGES-1][p*PORT_WIDTH +: PORT_WIDTH]);
          default: rdata_c = DATA_WIDTH'(flags_q[p*PORT_WIDTH +: PORT_WIDTH])
                           | (DATA_WIDTH'(irq_en_q[p]) << PORT_WIDTH);
        endcase
      end
    end
  end

  // Input synchronizer, edge-delay register and post-reset arming counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      delay_q   <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      delay_q <= sync_q[SYNC_STAGES-1];
      if (!armed_c) arm_cnt_q <= arm_cnt_q + ARM_WIDTH'(1);
    end
  end

  // Sticky flags (a new edge beats a same-cycle clear) and registered IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      out_irq <= 1'b0;
    end else begin
      flags_q <= (flags_q & ~clr_c) | rise_c;
      out_irq <= |(flags_q & ie_mask_c);
    end
  end

  // Port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port    <= '0;
      out_port_oe <= '0;
      irq_en_q    <= '0;
    end else begin
      for (int p = 0; p < int'(PORT_COUNT); p++) begin
        if (wr_out_c[p]) out_port[p*PORT_WIDTH +: PORT_WIDTH] <= in_data[PORT_WIDTH-1:0];
        if (wr_dir_c[p]) out_port_oe[p*PORT_WIDTH +: PORT_WIDTH] <= in_data[PORT_WIDTH-1:0];
        if (wr_flg_c[p]) irq_en_q[p] <= ie_wdata_c;
      end
    end
  end

  // Read port: data holds between reads, valid pulses per sampled read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data       <= '0;
      out_read_valid <= 1'b0;
    end else begin
      out_read_valid <= in_read_en;
      if (in_read_en) out_data <= rdata_c;
    end
  end

endmodule

// File: tb/tb_drf_gpio_ports.sv
// Self-checking bench for drf_gpio_ports (3 ports x 4 pins); reads are scored
// through an expected-value queue drained by a read-data monitor.
module tb_drf_gpio_ports;

  localparam int unsigned DW = 8;
  localparam int unsigned PC = 3;
  localparam int unsigned PW = 4;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_write_en;
  logic          in_read_en;
  logic [DW-1:0] out_data;
  logic          out_read_valid;
  logic [PC*PW-1:0] in_port;
  logic [PC*PW-1:0] out_port;
  logic [PC*PW-1:0] out_port_oe;
  logic          out_irq;

  int vectors;
  int miscompares;
  int reads_issued;
  int valid_seen;
  logic [31:0] exp_q[$];

  drf_gpio_ports #(
    .DATA_WIDTH(DW), .PORT_COUNT(PC), .PORT_WIDTH(PW), .SYNC_STAGES(2), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_data(in_data),
    .in_write_en(in_write_en), .in_read_en(in_read_en),
    .out_data(out_data), .out_read_valid(out_read_valid),
    .in_port(in_port), .out_port(out_port), .out_port_oe(out_port_oe),
    .out_irq(out_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    in_addr = addr;
    in_data = data;
    in_write_en = 1'b1;
    cycle(1);
    in_write_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp);
    in_addr = addr;
    in_read_en = 1'b1;
    exp_q.push_back(exp);
    reads_issued++;
    cycle(1);
    in_read_en = 1'b0;
  endtask

  // Read-data monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (!rst && out_read_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) check_val("spurious_read", 32'(out_data), 32'hDEAD);
      else check_val("read_data", 32'(out_data), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0; reads_issued = 0; valid_seen = 0;
    rst = 1'b1; in_addr = '0; in_data = '0; in_write_en = 1'b0; in_read_en = 1'b0;
    in_port = 12'hFFF;
    #2;
    check_val("rst_out_port", 32'(out_port), 32'h0);
    check_val("rst_oe", 32'(out_port_oe), 32'h0);
    check_val("rst_irq", 32'(out_irq), 32'h0);
    check_val("rst_valid", 32'(out_read_valid), 32'h0);
    @(posedge clk); #1;
    cycle(2);
    rst = 1'b0;
    cycle(10);

    // Pins high through reset must not raise flags once armed
    check_val("arm_irq", 32'(out_irq), 32'h0);
    rd(4'd3, 32'h00);
    rd(4'd7, 32'h00);
    rd(4'd11, 32'h00);
    rd(4'd2, 32'h0F);
    rd(4'd10, 32'h0F);
    cycle(1);

    // Output latch and direction
    wr(4'd0, 8'h05);
    check_val("out_port_p0", 32'(out_port), 32'h005);
    wr(4'd1, 8'h0F);
    check_val("oe_p0", 32'(out_port_oe), 32'h00F);
    rd(4'd0, 32'h05);
    check_val("rv_high", 32'(out_read_valid), 32'h1);
    cycle(1);
    check_val("rv_low", 32'(out_read_valid), 32'h0);
    check_val("rd_hold", 32'(out_data), 32'h05);
    rd(4'd1, 32'h0F);
    wr(4'd4, 8'hF3);
    check_val("upper_ignored", 32'(out_port), 32'h035);
    wr(4'd5, 8'hFA);
    rd(4'd4, 32'h03);
    rd(4'd5, 32'h0A);

    // Same-cycle read and write returns the pre-write value
    in_addr = 4'd4; in_data = 8'h09; in_write_en = 1'b1; in_read_en = 1'b1;
    exp_q.push_back(32'h03); reads_issued++;
    cycle(1);
    in_write_en = 1'b0; in_read_en = 1'b0;
    check_val("rw_port", 32'(out_port), 32'h095);
    rd(4'd4, 32'h09);

    // Rising edge on port 2 bit 1: flag after 3 edges, IRQ one edge later
    in_port[9] = 1'b0;
    cycle(4);
    wr(4'd11, 8'h10);
    rd(4'd11, 32'h10);
    in_port[9] = 1'b1;
    cycle(3);
    check_val("irq_before", 32'(out_irq), 32'h0);
    rd(4'd11, 32'h12);
    check_val("irq_asserted", 32'(out_irq), 32'h1);

    // Clear colliding with a new edge on the same bit: the set wins
    in_port[9] = 1'b0;
    cycle(4);
    in_port[9] = 1'b1;
    cycle(2);
    wr(4'd11, 8'h12);
    check_val("irq_collide", 32'(out_irq), 32'h1);
    rd(4'd11, 32'h12);
    cycle(2);
    wr(4'd11, 8'h12);
    check_val("irq_hold_one", 32'(out_irq), 32'h1);
    cycle(1);
    check_val("irq_dropped", 32'(out_irq), 32'h0);
    rd(4'd11, 32'h10);

    // Unmapped addresses and writes to IN
    rd(4'd15, 32'h00);
    rd(4'd12, 32'h00);
    wr(4'd12, 8'hFF);
    wr(4'd13, 8'hFF);
    check_val("oob_port", 32'(out_port), 32'h095);
    check_val("oob_oe", 32'(out_port_oe), 32'h0AF);
    wr(4'd2, 8'hAA);
    rd(4'd2, 32'h0F);
    rd(4'd0, 32'h05);

    // Asynchronous reset with flags pending and every latch bit high
    in_port[0] = 1'b0;
    cycle(4);
    wr(4'd3, 8'h10);
    in_port[0] = 1'b1;
    cycle(5);
    check_val("irq_p0", 32'(out_irq), 32'h1);
    wr(4'd0, 8'h0F); wr(4'd4, 8'h0F); wr(4'd8, 8'h0F);
    wr(4'd1, 8'h0F); wr(4'd5, 8'h0F); wr(4'd9, 8'h0F);
    check_val("pre_rst_port", 32'(out_port), 32'hFFF);
    rd(4'd3, 32'h11);
    cycle(1);
    check_val("pre_rst_data", 32'(out_data), 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_port", 32'(out_port), 32'h0);
    check_val("async_oe", 32'(out_port_oe), 32'h0);
    check_val("async_irq", 32'(out_irq), 32'h0);
    check_val("async_data", 32'(out_data), 32'h0);
    check_val("async_valid", 32'(out_read_valid), 32'h0);
    cycle(2);
    rst = 1'b0;
    cycle(10);
    rd(4'd3, 32'h00);
    rd(4'd11, 32'h00);
    rd(4'd0, 32'h00);
    check_val("rearm_irq", 32'(out_irq), 32'h0);
    cycle(2);

    check_val("queue_drained", 32'(exp_q.size()), 32'h0);
    check_val("valid_pulses", 32'(valid_seen), 32'(reads_issued));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
